// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline fetch slice.
package mips_pipe_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] PC_INC    = 32'd4;
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus; fetch is master, memory is slave.
interface fetch_stage_if;
  import mips_pipe_pkg::*;

  logic              req;
  logic [DATA_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: stall holds, flush loads a bubble, otherwise load or bubble.
module fetch_ifid_reg
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pcplus4,
  output logic [DATA_W-1:0] instrD,
  output logic [DATA_W-1:0] pcplus4D,
  output logic              validD
);
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (!stall) begin
      if (load && !flush) begin
        instr_d   = instr;
        pcplus4_d = pcplus4;
        valid_d   = 1'b1;
      end else begin
        instr_d   = NOP_INSTR;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instrD   = instr_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, variable-latency imem req/ack FSM and IF/ID register.
// Define FETCH_PERF_EN to add the perf_fetched/perf_bubbles/perf_flushes counters.
//
// state | meaning
// REQ   | request for pcF on the bus, waiting for ack
// HELD  | word fetched during a stall, parked in the buffer
// DRAIN | redirected while a request is in flight; waiting to discard its ack
module fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              pcsrcD,
  input  logic [DATA_W-1:0] pcbranchD,
  input  logic              jumpD,
  input  logic [DATA_W-1:0] pcjumpD,
  fetch_stage_if.master     imem,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes,
`endif
  output logic [DATA_W-1:0] instrD,
  output logic [DATA_W-1:0] pcplus4D,
  output logic              validD
);
  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] redir_pc_q, redir_pc_d;
  logic [DATA_W-1:0] buf_instr_q, buf_instr_d;
  logic [DATA_W-1:0] buf_pcplus4_q, buf_pcplus4_d;
  logic              req_q, req_d;

  logic              hold, redirect, deliver;
  logic [DATA_W-1:0] target, pcplus4, dlv_instr, dlv_pcplus4;

  assign hold     = stallF | stallD;
  assign redirect = (pcsrcD | jumpD) & ~stallD;
  assign target   = pcsrcD ? pcbranchD : pcjumpD;
  assign pcplus4  = pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pcplus4_d = buf_pcplus4_q;
    deliver       = 1'b0;
    dlv_instr     = imem.rdata;
    dlv_pcplus4   = pcplus4;
    case (state_q)
      REQ: begin
        if (imem.ack) begin
          if (redirect) begin
            pc_d = target;
          end else if (hold) begin
            buf_instr_d   = imem.rdata;
            buf_pcplus4_d = pcplus4;
            state_d       = HELD;
          end else begin
            deliver = 1'b1;
            pc_d    = pcplus4;
          end
        end else if (redirect) begin
          redir_pc_d = target;
          state_d    = DRAIN;
        end
      end
      HELD: begin
        dlv_instr   = buf_instr_q;
        dlv_pcplus4 = buf_pcplus4_q;
        if (redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!hold) begin
          deliver = 1'b1;
          pc_d    = pcplus4;
          state_d = REQ;
        end
      end
      DRAIN: begin
        // A redirect in the ack cycle still wins over the older target.
        if (redirect) redir_pc_d = target;
        if (imem.ack) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    req_d = (state_d != HELD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      redir_pc_q    <= '0;
      buf_instr_q   <= NOP_INSTR;
      buf_pcplus4_q <= '0;
      req_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_pcplus4_q <= buf_pcplus4_d;
      req_q         <= req_d;
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc_q;

  fetch_ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .stall    (stallD),
    .flush    (redirect),
    .load     (deliver),
    .instr    (dlv_instr),
    .pcplus4  (dlv_pcplus4),
    .instrD   (instrD),
    .pcplus4D (pcplus4D),
    .validD   (validD)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d, flushes_q, flushes_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, deliver & ~stallD};
    bubbles_d = bubbles_q + {31'd0, ~stallD & ~redirect & ~deliver};
    flushes_d = flushes_q + {31'd0, redirect};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`endif
endmodule
